latch_bank_sequencer: RTL and testbench

- Clocked sequencer that drives a WIDTH-bit bank of negative-gate D latches with async clear and preset.
- Presents the latch data inputs, the active-low gate, and the clear and preset controls.
- Shapes each control as a flop-driven pulse with programmable setup, pulse and hold spacing.
- Reads the latch outputs back one cycle after the hold window and reports a mismatch.
- Sits between a PicoBlaze output-port decode (req/op/wdata) and the latch bank.

---
 rtl/latch_bank_sequencer_if.sv | 15 +
 rtl/latch_bank_sequencer.sv | 139 +++++++++++++
 tb/tb_latch_bank_sequencer.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/latch_bank_sequencer_if.sv
`timescale 1ns/1ps
// Host-side port of the latch bank sequencer: request/op/data in, busy/ack/err back.
interface latch_bank_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             req;
  logic [1:0]       op;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             ack;
  logic             err;

  modport master (output req, op, wdata, input busy, ack, err);
  modport slave  (input req, op, wdata, output busy, ack, err);
endinterface

// File: rtl/latch_bank_sequencer.sv
`timescale 1ns/1ps
// Drives a bank of negative-gate D latches with async clear/preset using flop-shaped
// setup/pulse/hold windows, then compares the latch outputs against the expected value.
module latch_bank_sequencer #(
  parameter int WIDTH     = 8,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  latch_bank_sequencer_if.slave host,
  input  logic [WIDTH-1:0]      latch_q,
  output logic [WIDTH-1:0]      lat_d,
  output logic                  lat_g,
  output logic                  lat_clr,
  output logic                  lat_pre
);
  // state | meaning
  // IDLE  | waiting for req, all controls inactive
  // SETUP | lat_d settling ahead of the control pulse
  // PULSE | gate, clear or preset asserted
  // HOLD  | controls released, lat_d still held
  // CHECK | one-cycle ack, latch_q compared against exp

  localparam logic [1:0] OP_WRITE  = 2'b00;
  localparam logic [1:0] OP_CLEAR  = 2'b01;
  localparam logic [1:0] OP_PRESET = 2'b10;
  localparam logic [1:0] OP_CHECK  = 2'b11;

  localparam int MAX_CYC = (SETUP_CYC > PULSE_CYC)
                         ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                         : ((PULSE_CYC > HOLD_CYC) ? PULSE_CYC : HOLD_CYC);
  localparam int CW = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;

  // Counter is loaded with N-1 and the window ends on terminal count zero.
  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);

  generate
    if ((SETUP_CYC < 1) || (PULSE_CYC < 1) || (HOLD_CYC < 1)) begin : g_bad_param
      $error("latch_bank_sequencer: SETUP_CYC, PULSE_CYC and HOLD_CYC must all be >= 1");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, CHECK} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [1:0]       op_r;
  logic [WIDTH-1:0] exp_r;
  logic             busy_r, ack_r;
  logic             start;

  assign start = (state == IDLE) && host.req && (host.op != OP_CHECK);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (host.req) begin
          if (host.op == OP_CHECK) begin
            state_nxt = CHECK;
          end else begin
            state_nxt = SETUP;
            cnt_nxt   = SETUP_LD;
          end
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          state_nxt = PULSE;
          cnt_nxt   = PULSE_LD;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      PULSE: begin
        if (cnt == '0) begin
          state_nxt = HOLD;
          cnt_nxt   = HOLD_LD;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          state_nxt = CHECK;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      CHECK:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Controls are registered from the next state so every output pin is a flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      op_r    <= OP_WRITE;
      exp_r   <= '0;
      lat_d   <= '0;
      lat_g   <= 1'b1;
      lat_clr <= 1'b0;
      lat_pre <= 1'b0;
      busy_r  <= 1'b0;
      ack_r   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      busy_r  <= (state_nxt != IDLE);
      ack_r   <= (state_nxt == CHECK);
      lat_g   <= !((state_nxt == PULSE) && (op_r == OP_WRITE));
      lat_clr <= (state_nxt == PULSE) && (op_r == OP_CLEAR);
      lat_pre <= (state_nxt == PULSE) && (op_r == OP_PRESET);
      if (start) begin
        op_r <= host.op;
        case (host.op)
          OP_WRITE: begin
            lat_d <= host.wdata;
            exp_r <= host.wdata;
          end
          OP_CLEAR: exp_r <= '0;
          default:  exp_r <= '1;
        endcase
      end
    end
  end

  assign host.busy = busy_r;
  assign host.ack  = ack_r;
  assign host.err  = ack_r && (latch_q != exp_r);

endmodule

// File: tb/tb_latch_bank_sequencer.sv
`timescale 1ns/1ps
// Directed bench: behavioural latch bank, scoreboard of expected ack cycle/err per request.
module tb_latch_bank_sequencer;
  localparam int W = 8;
  localparam int S = 1;
  localparam int P = 2;
  localparam int H = 1;
  localparam logic [1:0] WR = 2'b00;
  localparam logic [1:0] CL = 2'b01;
  localparam logic [1:0] PR = 2'b10;
  localparam logic [1:0] RB = 2'b11;

  typedef struct {
    int   ack_cyc;
    logic err;
  } sb_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vec = 0;
  int bad = 0;
  sb_t sb[$];

  logic [W-1:0] exp_model = '0;
  logic [W-1:0] d_model = '0;
  logic         fault_en;
  logic [W-1:0] fault_val;

  logic [1:0]   ops   [4] = '{WR, CL, PR, WR};
  logic [W-1:0] datas [4] = '{8'h11, 8'h00, 8'h00, 8'h22};

  latch_bank_sequencer_if #(.WIDTH(W)) hif ();
  latch_bank_sequencer_if #(.WIDTH(W)) hif2 ();

  logic [W-1:0] latch_q, lat_d, mq;
  logic         lat_g, lat_clr, lat_pre;
  logic [W-1:0] latch_q2, lat_d2, mq2;
  logic         lat_g2, lat_clr2, lat_pre2;

  latch_bank_sequencer #(.WIDTH(W), .SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H)) dut (
    .clk(clk), .reset_n(reset_n), .host(hif), .latch_q(latch_q),
    .lat_d(lat_d), .lat_g(lat_g), .lat_clr(lat_clr), .lat_pre(lat_pre)
  );

  latch_bank_sequencer #(.WIDTH(W), .SETUP_CYC(3), .PULSE_CYC(1), .HOLD_CYC(4)) dut2 (
    .clk(clk), .reset_n(reset_n), .host(hif2), .latch_q(latch_q2),
    .lat_d(lat_d2), .lat_g(lat_g2), .lat_clr(lat_clr2), .lat_pre(lat_pre2)
  );

  // Latch bank model, evaluated mid-cycle when the flop-driven controls are stable.
  initial begin
    mq  = '0;
    mq2 = '0;
  end
  always @(negedge clk) begin
    if (lat_clr)     mq <= '0;
    else if (lat_pre) mq <= '1;
    else if (!lat_g)  mq <= lat_d;
    if (lat_clr2)      mq2 <= '0;
    else if (lat_pre2) mq2 <= '1;
    else if (!lat_g2)  mq2 <= lat_d2;
  end
  assign latch_q  = fault_en ? fault_val : mq;
  assign latch_q2 = mq2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vec++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [1:0] o, input logic [W-1:0] d, input int k);
    sb_t e;
    case (o)
      WR: begin exp_model = d; d_model = d; end
      CL: exp_model = '0;
      PR: exp_model = '1;
      default: ;
    endcase
    e.ack_cyc = (o == RB) ? k : k + S + P + H;
    e.err     = fault_en && (fault_val != exp_model);
    sb.push_back(e);
  endtask

  task automatic issue(input logic [1:0] o, input logic [W-1:0] d, output int k);
    @(negedge clk);
    hif.req = 1'b1; hif.op = o; hif.wdata = d;
    @(posedge clk); #1;
    k = cyc;
    hif.req = 1'b0;
    push(o, d, k);
  endtask

  // Walks the cycles following an accepted request and checks the control waveform.
  task automatic check_txn(input logic [1:0] o);
    int   nb;
    logic pulse;
    nb = (o == RB) ? 0 : S + P + H;
    for (int i = 0; i <= nb + 1; i++) begin
      @(negedge clk);
      pulse = (o != RB) && (i >= S) && (i < S + P);
      chk("busy", hif.busy, i <= nb);
      chk("lat_g", lat_g, !(pulse && o == WR));
      chk("lat_clr", lat_clr, pulse && o == CL);
      chk("lat_pre", lat_pre, pulse && o == PR);
      chk("lat_d", lat_d, d_model);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && hif.ack) begin
      chk("ack_has_expectation", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        sb_t e;
        e = sb.pop_front();
        chk("ack_cycle", cyc, e.ack_cyc);
        chk("err_on_ack", hif.err, e.err);
      end
    end
  end

  logic [W-1:0] prev_d = '0;
  logic         prev_busy = 1'b0;
  always @(negedge clk) begin
    if (reset_n) begin
      chk("ctl_overlap", $countones({~lat_g, lat_clr, lat_pre}) <= 1, 1);
      if (!hif.ack) chk("err_without_ack", hif.err, 0);
      if (lat_d !== prev_d) chk("lat_d_change_on_accept", hif.busy && !prev_busy, 1);
    end
    prev_d    <= lat_d;
    prev_busy <= hif.busy;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish, %0d vectors applied", vec);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int ack_at;
    int gcnt;
    reset_n = 1'b0;
    hif.req = 1'b0;  hif.op = WR;  hif.wdata = '0;
    hif2.req = 1'b0; hif2.op = WR; hif2.wdata = '0;
    fault_en = 1'b0; fault_val = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_lat_g", lat_g, 1);
    chk("rst_lat_clr", lat_clr, 0);
    chk("rst_lat_pre", lat_pre, 0);
    chk("rst_busy", hif.busy, 0);
    chk("rst_ack", hif.ack, 0);
    chk("rst_err", hif.err, 0);
    chk("rst_lat_d", lat_d, 0);
    reset_n = 1'b1;

    issue(WR, 8'hA5, k);
    check_txn(WR);

    issue(CL, 8'h00, k);
    check_txn(CL);
    chk("clear_latch_q", latch_q, 8'h00);
    issue(PR, 8'h00, k);
    check_txn(PR);
    chk("preset_latch_q", latch_q, 8'hFF);

    fault_en = 1'b1; fault_val = 8'h3D;
    issue(WR, 8'h3C, k);
    check_txn(WR);
    chk("err_after_ack", hif.err, 0);
    fault_val = 8'h3C;
    issue(RB, 8'h00, k);
    check_txn(RB);
    fault_en = 1'b0;

    // Request held high; op/data change while busy and must wait for the next idle edge.
    @(negedge clk);
    hif.req = 1'b1; hif.op = ops[0]; hif.wdata = datas[0];
    @(posedge clk); #1;
    k = cyc;
    push(ops[0], datas[0], k);
    for (int n = 1; n < 4; n++) begin
      hif.op = ops[n]; hif.wdata = datas[n];
      repeat (S + P + H + 2) @(posedge clk);
      #1;
      k += S + P + H + 2;
      push(ops[n], datas[n], k);
    end
    hif.req = 1'b0;
    repeat (S + P + H + 3) @(posedge clk);

    issue(WR, 8'h77, k);
    @(posedge clk); #1;
    chk("pulse_before_reset", lat_g, 0);
    reset_n = 1'b0;
    #1;
    chk("abort_lat_g", lat_g, 1);
    chk("abort_busy", hif.busy, 0);
    chk("abort_ack", hif.ack, 0);
    chk("abort_lat_d", lat_d, 0);
    sb.delete();
    exp_model = '0;
    d_model = '0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    fault_en = 1'b1; fault_val = 8'h00;
    issue(RB, 8'h00, k);
    check_txn(RB);
    fault_val = 8'h01;
    issue(RB, 8'h00, k);
    check_txn(RB);
    fault_en = 1'b0;

    @(negedge clk);
    hif2.req = 1'b1; hif2.op = WR; hif2.wdata = 8'h5A;
    @(posedge clk); #1;
    hif2.req = 1'b0;
    ack_at = -1;
    gcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("p2_lat_d", lat_d2, 8'h5A);
      chk("p2_busy", hif2.busy, 1);
      if (!lat_g2) gcnt++;
      if (hif2.ack) begin
        ack_at = i;
        chk("p2_err", hif2.err, 0);
        break;
      end
    end
    chk("p2_ack_latency", ack_at, 8);
    chk("p2_pulse_width", gcnt, 1);

    repeat (4) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
